// File: rtl/seq_signed_divider.sv
`timescale 1ns/1ps
// Sequential signed restoring divider: 2N-bit dividend by N-bit divisor,
// truncating like Verilog / and %, fixed N+2 cycle latency, start/busy/done handshake.
module seq_signed_divider #(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic signed [2*N-1:0] Dividend,
   input  logic signed [N-1:0]   Divisor,
   output logic signed [N-1:0]   Quotient,
   output logic signed [N-1:0]   Remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero,
   output logic                  overflow,
   output logic [7:0]            count
);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

   localparam logic [N:0] Q_MAX_POS = (N+1)'((2**(N-1)) - 1);
   localparam logic [N:0] Q_MAX_NEG = (N+1)'(2**(N-1));

   state_t         state;
   logic [2*N-1:0] a_reg;
   logic [N-1:0]   b_reg;
   logic [N-1:0]   mag_b;
   logic [N:0]     p;
   logic [N-1:0]   shq;
   logic           sign_q;
   logic           sign_r;
   logic           pre_ovf;

   logic [2*N-1:0] mag_a_c;
   logic [N-1:0]   mag_b_c;
   logic [N:0]     p_shift;
   logic [N:0]     p_next;
   logic           p_ge;
   logic [N-1:0]   q_fix;
   logic [N-1:0]   r_fix;
   logic           range_ovf;

   // shq starts as the low dividend half and fills with quotient bits from the LSB as it shifts out.
   always_comb begin
      mag_a_c   = a_reg[2*N-1] ? -a_reg : a_reg;
      mag_b_c   = b_reg[N-1] ? -b_reg : b_reg;
      p_shift   = {p[N-1:0], shq[N-1]};
      p_ge      = (p_shift >= {1'b0, mag_b});
      p_next    = p_ge ? (p_shift - {1'b0, mag_b}) : p_shift;
      q_fix     = sign_q ? -shq : shq;
      r_fix     = sign_r ? -p[N-1:0] : p[N-1:0];
      range_ovf = pre_ovf
                | (!sign_q && ({1'b0, shq} > Q_MAX_POS))
                | ( sign_q && ({1'b0, shq} > Q_MAX_NEG));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         mag_b     <= '0;
         p         <= '0;
         shq       <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         pre_ovf   <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         count     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg    <= Dividend;
                  b_reg    <= Divisor;
                  div_zero <= 1'b0;
                  overflow <= 1'b0;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               mag_b    <= mag_b_c;
               sign_q   <= a_reg[2*N-1] ^ b_reg[N-1];
               sign_r   <= a_reg[2*N-1];
               div_zero <= (b_reg == '0);
               pre_ovf  <= (mag_a_c[2*N-1:N] >= mag_b_c);
               p        <= {1'b0, mag_a_c[2*N-1:N]};
               shq      <= mag_a_c[N-1:0];
               state    <= ITER;
            end
            ITER: begin
               p     <= p_next;
               shq   <= {shq[N-2:0], p_ge};
               count <= count + 8'd1;
               if (count == 8'(N-1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               // Divide-by-zero takes precedence; its quotient is meaningless, so overflow stays low.
               if (div_zero || range_ovf) begin
                  Quotient  <= '0;
                  Remainder <= '0;
                  overflow  <= range_ovf & ~div_zero;
               end else begin
                  Quotient  <= $signed(q_fix);
                  Remainder <= $signed(r_fix);
                  overflow  <= 1'b0;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
`timescale 1ns/1ps
// Self-checking bench for seq_signed_divider: a cycle-level behavioural model
// checked every cycle, plus literal cases, handshake/reset scenarios, random ops and a full sweep.
module tb_seq_signed_divider;

   localparam int N   = 4;
   localparam int LAT = N + 2;

   typedef struct packed {
      logic signed [N-1:0] q;
      logic signed [N-1:0] r;
      logic                dz;
      logic                ovf;
   } res_t;

   logic                  clk   = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  start = 1'b0;
   logic signed [2*N-1:0] da    = '0;
   logic signed [N-1:0]   db    = '0;
   logic signed [N-1:0]   Quotient;
   logic signed [N-1:0]   Remainder;
   logic                  busy;
   logic                  done;
   logic                  div_zero;
   logic                  overflow;
   logic [7:0]            count;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   logic                m_active = 1'b0;
   int                  m_ph     = 0;
   res_t                m_res    = '0;
   logic signed [N-1:0] m_q      = '0;
   logic signed [N-1:0] m_r      = '0;
   logic                m_done   = 1'b0;
   logic                m_dz     = 1'b0;
   logic                m_ovf    = 1'b0;
   int                  m_count  = 0;

   always #5 clk = ~clk;

   seq_signed_divider #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Dividend  (da),
      .Divisor   (db),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .overflow  (overflow),
      .count     (count)
   );

   // Reference result straight from truncating integer division and the signed range rule.
   function automatic res_t ref_div(input int a, input int b);
      res_t res;
      int   q;
      int   r;
      res = '0;
      if (b == 0) begin
         res.dz = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         if (q > (2**(N-1)) - 1 || q < -(2**(N-1))) begin
            res.ovf = 1'b1;
         end else begin
            res.q = q[N-1:0];
            res.r = r[N-1:0];
         end
      end
      return res;
   endfunction

   // Timing model: busy from the accepting edge for N+2 edges, results and done on the last one.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_ph     <= 0;
         m_res    <= '0;
         m_q      <= '0;
         m_r      <= '0;
         m_done   <= 1'b0;
         m_dz     <= 1'b0;
         m_ovf    <= 1'b0;
         m_count  <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active <= 1'b1;
               m_ph     <= 0;
               m_res    <= ref_div(int'(da), int'(db));
               m_dz     <= 1'b0;
               m_ovf    <= 1'b0;
               m_count  <= 0;
            end
         end else begin
            m_ph    <= m_ph + 1;
            m_count <= (m_ph < N) ? m_ph : N;
            if (m_ph == 0) m_dz <= m_res.dz;
            if (m_ph == LAT - 1) begin
               m_q      <= m_res.q;
               m_r      <= m_res.r;
               m_ovf    <= m_res.ovf;
               m_done   <= 1'b1;
               m_active <= 1'b0;
            end
         end
      end
   end

   task automatic cmp(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp("cyc_busy",      int'(busy),     int'(m_active));
         cmp("cyc_done",      int'(done),     int'(m_done));
         cmp("cyc_count",     int'(count),    m_count);
         cmp("cyc_div_zero",  int'(div_zero), int'(m_dz));
         cmp("cyc_overflow",  int'(overflow), int'(m_ovf));
         cmp("cyc_Quotient",  int'(Quotient), int'(m_q));
         cmp("cyc_Remainder", int'(Remainder), int'(m_r));
      end
   end

   task automatic checkOutput(input string name, input int q, input int r, input int dz, input int ovf);
      cmp({name, "_Quotient"},  int'(Quotient),  q);
      cmp({name, "_Remainder"}, int'(Remainder), r);
      cmp({name, "_div_zero"},  int'(div_zero),  dz);
      cmp({name, "_overflow"},  int'(overflow),  ovf);
   endtask

   task automatic checkReset(input string name);
      cmp({name, "_Quotient"},  int'(Quotient),  0);
      cmp({name, "_Remainder"}, int'(Remainder), 0);
      cmp({name, "_busy"},      int'(busy),      0);
      cmp({name, "_done"},      int'(done),      0);
      cmp({name, "_div_zero"},  int'(div_zero),  0);
      cmp({name, "_overflow"},  int'(overflow),  0);
      cmp({name, "_count"},     int'(count),     0);
   endtask

   // Issues one op from a negedge and returns at the negedge where done is seen; lat counts negedges after the accept.
   task automatic applyStimulus(input logic signed [2*N-1:0] a, input logic signed [N-1:0] b,
                                input bit noisy, output int lat);
      int guard;
      guard = 0;
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmp("idle_wait", int'(busy), 0);
      da    = a;
      db    = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      da    = 8'($urandom);
      db    = 4'($urandom);
      lat   = -1;
      for (int i = 0; i <= LAT + 4; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
         if (noisy) start = 1'($urandom_range(0, 1));
         da = 8'($urandom);
         db = 4'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic runCase(input string name, input int a, input int b,
                          input int q, input int r, input int dz, input int ovf);
      int lat;
      applyStimulus(8'(a), 4'(b), 1'b0, lat);
      cmp({name, "_latency"}, lat, LAT);
      checkOutput(name, q, r, dz, ovf);
   endtask

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog expired t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   lat;
      res_t exp_res;
      logic signed [2*N-1:0] ra;
      logic signed [N-1:0]   rb;

      #2 rst_n = 1'b0;
      #1 checkReset("por");
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      exp_res = ref_div(-7, 2);
      cmp("model_q_m7_2", int'(exp_res.q), -3);
      cmp("model_r_m7_2", int'(exp_res.r), -1);
      exp_res = ref_div(-8, 1);
      cmp("model_q_m8_1", int'(exp_res.q), -8);
      exp_res = ref_div(8, 1);
      cmp("model_ovf_8_1", int'(exp_res.ovf), 1);
      exp_res = ref_div(5, 0);
      cmp("model_dz_5_0", int'(exp_res.dz), 1);
      cmp("model_ovf_5_0", int'(exp_res.ovf), 0);

      runCase("6/3",     6,    3,  2,  0, 0, 0);
      runCase("-7/2",    -7,   2, -3, -1, 0, 0);
      runCase("7/-2",    7,   -2, -3,  1, 0, 0);
      runCase("-7/-2",   -7,  -2,  3, -1, 0, 0);
      runCase("-8/1",    -8,   1, -8,  0, 0, 0);
      runCase("8/1",     8,    1,  0,  0, 0, 1);
      runCase("100/3",   100,  3,  0,  0, 0, 1);
      runCase("-128/-8", -128, -8, 0,  0, 0, 1);
      runCase("5/0",     5,    0,  0,  0, 1, 0);
      runCase("12/4",    12,   4,  3,  0, 0, 0);

      $display("[TB] start held high with operands changing while busy");
      da    = 8'sd6;
      db    = 4'sd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      da  = 8'($urandom);
      db  = 4'($urandom);
      lat = -1;
      for (int i = 1; i <= LAT + 4; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         da = 8'($urandom);
         db = 4'($urandom);
      end
      cmp("hold_latency", lat, LAT);
      checkOutput("hold", 2, 0, 0, 0);
      da = 8'sd12;
      db = 4'sd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      for (int i = 1; i <= LAT + 4; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      cmp("b2b_latency", lat, LAT);
      checkOutput("b2b", 3, 0, 0, 0);

      $display("[TB] reset in the middle of an operation");
      @(negedge clk);
      da    = 8'sd20;
      db    = 4'sd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 checkReset("midop");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      runCase("post_rst", 12, 4, 3, 0, 0, 0);

      $display("[TB] random operations");
      repeat (300) begin
         ra = 8'($urandom);
         rb = 4'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(ra, rb, 1'b1, lat);
         exp_res = ref_div(int'(ra), int'(rb));
         cmp("rand_latency", lat, LAT);
         checkOutput("rand", int'(exp_res.q), int'(exp_res.r), int'(exp_res.dz), int'(exp_res.ovf));
      end

      $display("[TB] exhaustive sweep");
      for (int a = -128; a <= 127; a++) begin
         for (int b = -8; b <= 7; b++) begin
            applyStimulus(8'(a), 4'(b), 1'b0, lat);
            exp_res = ref_div(a, b);
            cmp("sweep_latency", lat, LAT);
            checkOutput("sweep", int'(exp_res.q), int'(exp_res.r), int'(exp_res.dz), int'(exp_res.ovf));
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
